store_rmw_unit: RTL and testbench
=================================

// Module: store_rmw_unit
// PURPOSE
//  Store-path companion to the load sign-extension datapath: narrows a 32-bit register value to
//  byte/halfword and writes it into word-organised data memory via read-modify-write (RMW).
//  Sits between the CPU store stage and the 32-bit data memory port; stalls the core via busy_o.
//  Full-word stores bypass the read phase. Little-endian lane order.
// PARAMETERS
//  ADDR_W       32   byte-address width
//  TIMEOUT_CYC  255  max cycles waiting for mem_rvalid_i/mem_wack_i before error abort (>=1)
// PORTS
//  clk_i         in   1       clock, rising edge
//  rst_i         in   1       asynchronous, active-high reset
//  req_i         in   1       store request; sampled only in IDLE
//  addr_i        in   ADDR_W  byte address of store
//  wdata_i       in   32      register value; only low byte/half used for narrow stores
//  size_i        in   2       00=byte, 01=half, 10=word, 11=illegal
//  busy_o        out  1       high from accept cycle until done/err cycle inclusive
//  done_o        out  1       one-cycle pulse: store committed
//  err_o         out  1       one-cycle pulse: misaligned/illegal size/timeout; memory untouched
//  mem_addr_o    out  ADDR_W  word address to memory ({addr[ADDR_W-1:2],2'b00})
//  mem_rd_o      out  1       read strobe, one cycle
//  mem_rdata_i   in   32      read data, valid with mem_rvalid_i
//  mem_rvalid_i  in   1       read data valid
//  mem_wr_o      out  1       write strobe, held until mem_wack_i
//  mem_wdata_o   out  32      merged write word
//  mem_wack_i    in   1       write accepted
// BEHAVIOUR
//  - Reset: state=IDLE; busy_o, done_o, err_o, mem_rd_o, mem_wr_o = 0; mem_addr_o, mem_wdata_o = 0.
//  - States: IDLE, RD_REQ, RD_WAIT, WR, DONE, ERR.
//  - IDLE: req_i=1 -> latch addr/wdata/size; illegal (size=11, half with addr[0]=1,
//    word with addr[1:0]!=0) -> ERR; word -> WR; byte/half -> RD_REQ.
//  - RD_REQ: mem_rd_o=1 one cycle -> RD_WAIT.
//  - RD_WAIT: on mem_rvalid_i, merge -> WR; timeout counter hits TIMEOUT_CYC -> ERR.
//  - Merge: byte -> lane addr[1:0] gets wdata[7:0]; half -> lane pair addr[1] gets wdata[15:0];
//    remaining lanes keep mem_rdata_i. Upper bits of wdata_i ignored (truncation, no check).
//  - WR: mem_wr_o=1, mem_wdata_o stable; mem_wack_i -> DONE; timeout -> ERR (mem_wr_o drops).
//  - DONE: done_o=1 one cycle -> IDLE. ERR: err_o=1 one cycle -> IDLE.
//  - busy_o=1 in every state except IDLE; req_i in non-IDLE states ignored (no queueing).
//  - Timeout counter clears on every state entry; mem_rvalid_i and timeout same cycle: data wins.
//  - Min latency accept->done: word 2 cycles (WR with same-cycle ack, DONE); narrow 4 cycles.
//  - mem_rvalid_i outside RD_WAIT and mem_wack_i outside WR are ignored.
//  - Reset mid-operation: immediate return to IDLE, all strobes low, no partial write issued.
// STRUCTURE
//  - Shared package store_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings (also used by load
//    extension path), state enum for store_rmw_unit.
//  - Sub-module lane_merge (combinational): old_word, data, size, offset -> merged word.
//  - Top: FSM, request latch, timeout counter.
// TESTING
//  - Byte: addr=0x13, wdata=0xAABBCC5A, mem word=0x11223344 -> mem_wdata_o=0x5A223344, done_o.
//  - Half: addr=0x22, wdata=0x0000BEEF, mem=0xDEADC0DE -> mem_wdata_o=0xBEEFC0DE; addr=0x21 -> err_o, no mem_rd_o.
//  - Word: addr=0x40, wdata=0x12345678, ack same cycle -> no mem_rd_o, done_o 2 cycles after accept.
//  - Timeout: TIMEOUT_CYC=4, mem_rvalid_i never -> err_o after 4 wait cycles, mem_wr_o never high.
//  - rst_i asserted during WR -> mem_wr_o, busy_o low same cycle; next req_i accepted normally.
//  - req_i held high throughout two stores: second accepted only after done_o cycle, in IDLE.

Source files
------------

// File: rtl/store_pkg.sv
// ---------------------------------------------------------------------------
// store_pkg
//   Shared definitions for the store path (and the load extension path):
//   access-size encodings, store_rmw_unit FSM state codes, and a helper that
//   flags illegal or misaligned accesses.
// ---------------------------------------------------------------------------
package store_pkg;

  // Access-size encodings, shared with the load sign-extension datapath.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // store_rmw_unit FSM state codes.
  typedef logic [2:0] store_state_t;
  localparam store_state_t ST_IDLE    = 3'd0;
  localparam store_state_t ST_RD_REQ  = 3'd1;
  localparam store_state_t ST_RD_WAIT = 3'd2;
  localparam store_state_t ST_WR      = 3'd3;
  localparam store_state_t ST_DONE    = 3'd4;
  localparam store_state_t ST_ERR     = 3'd5;

  // True when a store of this size cannot be issued at this byte offset.
  function automatic logic size_illegal(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lane_merge.sv
// ---------------------------------------------------------------------------
// lane_merge
//   Combinational little-endian lane merge for read-modify-write stores.
//   Ports:
//     old_word  in  32  word read back from memory
//     data      in  32  store data (only low byte/half used for narrow sizes)
//     size      in  2   access size (store_pkg encodings)
//     offset    in  2   byte offset of the store within the word
//     merged    out 32  old_word with the addressed lane(s) replaced
// ---------------------------------------------------------------------------
module lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       sel;
      logic [7:0] src;

      always_comb begin
        sel = 1'b0;
        src = data[8*gi +: 8];
        case (size)
          SIZE_BYTE: begin
            sel = (offset == 2'(gi));
            src = data[7:0];
          end
          SIZE_HALF: begin
            // Lane pair chosen by offset[1]; low half of data feeds it.
            sel = (offset[1] == 1'(gi / 2));
            src = data[8*(gi % 2) +: 8];
          end
          SIZE_WORD: begin
            sel = 1'b1;
            src = data[8*gi +: 8];
          end
          default: begin
            sel = 1'b0;
            src = data[8*gi +: 8];
          end
        endcase
      end

      assign merged[8*gi +: 8] = sel ? src : old_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/store_rmw_unit.sv
// ---------------------------------------------------------------------------
// store_rmw_unit
//   Narrows a register value to byte/half/word and writes it to a word-wide
//   data memory. Narrow stores read the word, merge the new lane(s), and
//   write it back; word stores go straight to the write phase.
//   Ports:
//     clk_i, rst_i          clock, async active-high reset
//     req_i/addr_i/wdata_i/size_i   store request (sampled in IDLE only)
//     busy_o                high in every non-IDLE state
//     done_o / err_o        one-cycle completion / abort pulses
//     mem_addr_o            word-aligned memory address
//     mem_rd_o, mem_rdata_i, mem_rvalid_i   read phase
//     mem_wr_o, mem_wdata_o, mem_wack_i     write phase
// ---------------------------------------------------------------------------
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        size_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              mem_wr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_wack_i
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  // Counter value in the last permitted wait cycle of a phase.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  store_state_t      state_reg;
  logic [1:0]        off_reg;
  logic [1:0]        size_reg;
  logic [31:0]       wdata_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic [31:0]       merged;
  logic              timeout_hit;

  lane_merge u_lane_merge (
    .old_word (mem_rdata_i),
    .data     (wdata_reg),
    .size     (size_reg),
    .offset   (off_reg),
    .merged   (merged)
  );

  assign timeout_hit = (cnt_reg == CNT_LAST);

  // Strobes decode straight from the state register so an asynchronous
  // reset drops them in the same cycle, with no partial write left behind.
  assign busy_o      = (state_reg != ST_IDLE);
  assign done_o      = (state_reg == ST_DONE);
  assign err_o       = (state_reg == ST_ERR);
  assign mem_rd_o    = (state_reg == ST_RD_REQ);
  assign mem_wr_o    = (state_reg == ST_WR);
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      off_reg       <= 2'b00;
      size_reg      <= SIZE_BYTE;
      wdata_reg     <= '0;
      cnt_reg       <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_i) begin
            off_reg      <= addr_i[1:0];
            size_reg     <= size_i;
            wdata_reg    <= wdata_i;
            mem_addr_reg <= {addr_i[ADDR_W-1:2], 2'b00};
            cnt_reg      <= '0;
            if (size_illegal(size_i, addr_i[1:0])) begin
              state_reg <= ST_ERR;
            end else if (size_i == SIZE_WORD) begin
              // Full word needs no merge: write data is the register value.
              mem_wdata_reg <= wdata_i;
              state_reg     <= ST_WR;
            end else begin
              state_reg <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          cnt_reg   <= '0;
          state_reg <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // Data arriving in the final wait cycle still wins over timeout.
          if (mem_rvalid_i) begin
            mem_wdata_reg <= merged;
            cnt_reg       <= '0;
            state_reg     <= ST_WR;
          end else if (timeout_hit) begin
            cnt_reg   <= '0;
            state_reg <= ST_ERR;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_WR: begin
          if (mem_wack_i) begin
            cnt_reg   <= '0;
            state_reg <= ST_DONE;
          end else if (timeout_hit) begin
            cnt_reg   <= '0;
            state_reg <= ST_ERR;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: begin
          cnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
        ST_ERR: begin
          cnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
module tb_store_rmw_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [1:0]  size_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;
  logic        mem_wr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_wack_i;

  int checks = 0;
  int errors = 0;

  // Memory responder knobs: rd_lat = cycles after mem_rd_o until rvalid
  // (0 = never); wack_lat = WR cycles before ack (0 = same cycle, -1 = never).
  int          rd_lat   = 1;
  int          wack_lat = 0;
  logic [31:0] mem_word = 32'h0;
  int          rd_count = 0;
  int          wr_count = 0;
  wr_t         exp_q[$];

  store_rmw_unit #(
    .ADDR_W      (32),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .size_i       (size_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rd_o     (mem_rd_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_wr_o     (mem_wr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wack_i   (mem_wack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Independent merge model: mask-and-shift rather than per-lane selection.
  function automatic logic [31:0] model(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] addr, input logic [1:0] size);
    int          sh;
    logic [31:0] m;
    if (size == 2'b00) begin
      sh = 8 * int'(addr[1:0]);
      m  = 32'h0000_00FF << sh;
    end else if (size == 2'b01) begin
      sh = 16 * int'(addr[1]);
      m  = 32'h0000_FFFF << sh;
    end else begin
      sh = 0;
      m  = 32'hFFFF_FFFF;
    end
    return (old & ~m) | ((wd << sh) & m);
  endfunction

  // Memory responder and write scoreboard, acting on falling edges.
  initial begin : responder
    int rd_cnt;
    int wr_cyc;
    wr_t e;
    rd_cnt = 0;
    wr_cyc = 0;
    mem_rvalid_i = 1'b0;
    mem_wack_i   = 1'b0;
    mem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem_word;
        end
      end
      if (mem_rd_o) begin
        rd_count++;
        if (rd_lat > 0) rd_cnt = rd_lat;
      end
      mem_wack_i = mem_wr_o && (wack_lat >= 0) && (wr_cyc >= wack_lat);
      if (mem_wr_o) begin
        wr_count++;
        wr_cyc++;
      end else begin
        wr_cyc = 0;
      end
      if (mem_wr_o && mem_wack_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", mem_wdata_o, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr_o, e.addr);
          check("wr_data", mem_wdata_o, e.data);
          $display("write  addr=0x%08h data=0x%08h", mem_addr_o, mem_wdata_o);
        end
      end
    end
  end

  // Issue one store and follow it to done/err, checking latency and strobes.
  task automatic run_store(input string name, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] size, input logic [31:0] old,
                           input logic [31:0] exp_word, input bit exp_err,
                           input int exp_lat, input int exp_rds);
    int n;
    int rd0;
    int wr0;
    rd0 = rd_count;
    wr0 = wr_count;
    mem_word = old;
    if (!exp_err) exp_q.push_back('{addr: {addr[31:2], 2'b00}, data: exp_word});
    req_i   = 1'b1;
    addr_i  = addr;
    wdata_i = wd;
    size_i  = size;
    @(negedge clk_i);
    req_i = 1'b0;
    n = 1;
    check({name, "_busy"}, 32'(busy_o), 32'd1);
    while (!(done_o || err_o) && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_done"}, 32'(done_o), 32'(!exp_err));
    check({name, "_err"}, 32'(err_o), 32'(exp_err));
    check({name, "_lat"}, 32'(n), 32'(exp_lat));
    check({name, "_rds"}, 32'(rd_count - rd0), 32'(exp_rds));
    if (exp_err) check({name, "_no_wr"}, 32'(wr_count - wr0), 32'd0);
    @(negedge clk_i);
    check({name, "_idle"}, {29'd0, busy_o, done_o, err_o}, 32'd0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    $display("store  %s addr=0x%08h wdata=0x%08h size=%0d -> %s after %0d cycles",
             name, addr, wd, size, exp_err ? "err" : "done", n);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst_i   = 1'b1;
    req_i   = 1'b0;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
    size_i  = 2'b00;
    repeat (3) @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_rd", 32'(mem_rd_o), 32'd0);
    check("rst_wr", 32'(mem_wr_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Narrow and word stores, legal and illegal.
    rd_lat = 1; wack_lat = 0;
    run_store("byte13", 32'h13, 32'hAABBCC5A, 2'b00, 32'h11223344, 32'h5A223344, 0, 4, 1);
    run_store("byte10", 32'h10, 32'h00000077, 2'b00, 32'h11223344,
              model(32'h11223344, 32'h77, 32'h10, 2'b00), 0, 4, 1);
    run_store("half22", 32'h22, 32'h0000BEEF, 2'b01, 32'hDEADC0DE, 32'hBEEFC0DE, 0, 4, 1);
    run_store("half21", 32'h21, 32'h0000BEEF, 2'b01, 32'hDEADC0DE, 32'h0, 1, 1, 0);
    run_store("word40", 32'h40, 32'h12345678, 2'b10, 32'h0, 32'h12345678, 0, 2, 0);
    run_store("word42", 32'h42, 32'h12345678, 2'b10, 32'h0, 32'h0, 1, 1, 0);
    run_store("size11", 32'h48, 32'h12345678, 2'b11, 32'h0, 32'h0, 1, 1, 0);

    // Read data arriving in the last wait cycle beats the timeout.
    rd_lat = 4;
    run_store("half20", 32'h20, 32'h99991234, 2'b01, 32'hDEADC0DE,
              model(32'hDEADC0DE, 32'h99991234, 32'h20, 2'b01), 0, 7, 1);

    // Read never returns: abort after four wait cycles, no write.
    rd_lat = 0;
    run_store("rd_tmo", 32'h31, 32'h000000AB, 2'b00, 32'h0, 32'h0, 1, 6, 1);

    // Reset asserted while the write strobe is up.
    rd_lat = 1; wack_lat = -1;
    req_i = 1'b1; addr_i = 32'h11; wdata_i = 32'h000000EE; size_i = 2'b00;
    @(negedge clk_i);
    req_i = 1'b0;
    n = 1;
    while (!mem_wr_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    check("rstwr_wr_seen", 32'(mem_wr_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("rstwr_wr_low", 32'(mem_wr_o), 32'd0);
    check("rstwr_busy_low", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    wack_lat = 0;
    $display("store  reset during write aborted");
    @(negedge clk_i);
    run_store("word_after_rst", 32'h40, 32'h0BADF00D, 2'b10, 32'h0, 32'h0BADF00D, 0, 2, 0);

    // req_i held high across two word stores; data changes after first accept.
    wack_lat = 1;
    exp_q.push_back('{addr: 32'h44, data: 32'h01020304});
    exp_q.push_back('{addr: 32'h44, data: 32'hCAFEF00D});
    req_i = 1'b1; addr_i = 32'h44; wdata_i = 32'h01020304; size_i = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      if (k == 1) wdata_i = 32'hCAFEF00D;
      if (k == 3) check("held_done1", 32'(done_o), 32'd1);
      if (k == 4) check("held_idle_gap", 32'(busy_o), 32'd0);
      if (k == 5) check("held_busy2", 32'(busy_o), 32'd1);
      if (k == 7) begin
        check("held_done2", 32'(done_o), 32'd1);
        req_i = 1'b0;
      end
      if (k == 8) begin
        check("held_idle_end", 32'(busy_o), 32'd0);
        check("held_sb_empty", 32'(exp_q.size()), 32'd0);
      end
    end
    $display("store  back-to-back held request completed");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
